// File: rtl/isqrt_if.sv
// Request/response bundle for the isqrt responders.
//   x_vld / x : request strobe and unsigned radicand (initiator -> responder)
//   busy      : responder has an operation in flight; x_vld ignored while high
//   y_vld / y : one-cycle result strobe and floor(sqrt(x)) (responder -> initiator)
interface isqrt_if #(
  parameter int N = 32
);
  logic           x_vld;
  logic [N-1:0]   x;
  logic           busy;
  logic           y_vld;
  logic [N/2-1:0] y;

  modport master (output x_vld, output x, input busy, input y_vld, input y);
  modport slave  (input x_vld, input x, output busy, output y_vld, output y);
endinterface

// File: rtl/isqrt_iter.sv
// Iterative integer square root, one result bit per clock.
// Computes y = floor(sqrt(x)) with the digit-by-digit method: each CALC edge
// brings in the next two radicand bits and decides one root bit.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   s   : isqrt_if slave (x_vld, x in; busy, y_vld, y out)
// Latency is fixed at N/2 iterations after the accepting edge, independent of x.
module isqrt_iter #(
  parameter int N = 32
) (
  input logic    clk,
  input logic    rst,
  isqrt_if.slave s
);

  localparam int RW    = N / 2;
  localparam int REM_W = RW + 2;
  localparam int CW    = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;

  logic [N-1:0]       r_sh;
  logic [REM_W-1:0]   r_rem;
  logic [RW-1:0]      r_root;
  logic [CW-1:0]      r_cnt;
  logic [RW-1:0]      r_y;
  logic               r_yvld;

  logic [REM_W-1:0]   w_rem_t;
  logic [REM_W-1:0]   w_trial;
  logic               w_ge;
  logic [REM_W-1:0]   w_rem_nxt;
  logic [RW-1:0]      w_root_nxt;
  logic               w_last;

  // One iteration of the recurrence. The remainder is bounded by 2*root, so
  // its top two bits are always zero when it is shifted; they are folded into
  // the decision so the full register takes part in the compare.
  assign w_rem_t    = {r_rem[REM_W-3:0], r_sh[N-1 -: 2]};
  assign w_trial    = {r_root, 2'b01};
  assign w_ge       = (r_rem[REM_W-1 -: 2] != 2'b00) || (w_rem_t >= w_trial);
  assign w_rem_nxt  = w_ge ? (w_rem_t - w_trial) : w_rem_t;
  assign w_root_nxt = {r_root[RW-2:0], w_ge};
  assign w_last     = (r_cnt == CW'(RW - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (s.x_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_yvld <= 1'b0;
    end else begin
      r_yvld <= 1'b0;
      if (w_accept) begin
        r_sh   <= s.x;
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= '0;
      end else if (r_state == CALC) begin
        r_sh   <= {r_sh[N-3:0], 2'b00};
        r_rem  <= w_rem_nxt;
        r_root <= w_root_nxt;
        r_cnt  <= r_cnt + CW'(1);
        // Last iteration: publish the root directly, no separate done state.
        if (w_last) begin
          r_y    <= w_root_nxt;
          r_yvld <= 1'b1;
        end
      end
    end
  end

  assign s.busy  = (r_state == CALC);
  assign s.y_vld = r_yvld;
  assign s.y     = r_y;

endmodule
